// File: rtl/ddc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ddc_capture_ctrl
// Purpose  : Sequences DDC chain reset, settle-discard and N-word I/Q capture.
// Revision : 1.0 - initial release
// ============================================================================
module ddc_capture_ctrl #(
    parameter logic [31:0] FREQ_DEFAULT   = 32'h64000000,
    parameter int          RST_CYCLES     = 16,
    parameter int          SETTLE_SAMPLES = 64,
    parameter int          LEN_W          = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      cfg_freq,
    input  logic             cfg_freq_we,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      dsp_data,
    input  logic             dsp_valid,
    output logic [31:0]      phi_inc,
    output logic             chain_rst_n,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             cfg_rej,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RST_CHAIN = 2'd1,
        S_SETTLE    = 2'd2,
        S_CAPTURE   = 2'd3
    } state_t;

    localparam logic [15:0]      C_RST_LAST    = 16'(RST_CYCLES - 1);
    localparam logic [15:0]      C_SETTLE_LAST = 16'(SETTLE_SAMPLES - 1);
    localparam logic [LEN_W-1:0] C_LEN_ONE     = LEN_W'(1);

    state_t           r_state;
    logic [15:0]      r_phase_cnt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_acc;
    logic [31:0]      r_phi_inc;
    logic             r_chain_rst_n;
    logic [31:0]      r_out_data;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_busy;
    logic             r_done;
    logic             r_cfg_rej;
    logic             r_overflow;

    logic             w_drain;
    logic             w_want;
    logic             w_room;
    logic [LEN_W-1:0] w_acc_next;

    // A sample is wanted only until the len-th one has been loaded.
    assign w_drain    = r_out_valid & out_ready;
    assign w_want     = dsp_valid & (r_acc < r_len);
    assign w_room     = ~r_out_valid | w_drain;
    assign w_acc_next = r_acc + C_LEN_ONE;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_phase_cnt   <= '0;
            r_len         <= '0;
            r_acc         <= '0;
            r_phi_inc     <= FREQ_DEFAULT;
            r_chain_rst_n <= 1'b0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_cfg_rej     <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_rej <= 1'b0;

            if (cfg_freq_we) begin
                if (r_state == S_IDLE)
                    r_phi_inc <= cfg_freq;
                else
                    r_cfg_rej <= 1'b1;
            end

            if (abort && (r_state != S_IDLE)) begin
                r_state       <= S_IDLE;
                r_busy        <= 1'b0;
                r_out_valid   <= 1'b0;
                r_out_last    <= 1'b0;
                r_chain_rst_n <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_chain_rst_n <= 1'b1;
                        if (start) begin
                            if (cfg_len != '0) begin
                                r_len         <= cfg_len;
                                r_acc         <= '0;
                                r_phase_cnt   <= '0;
                                r_overflow    <= 1'b0;
                                r_chain_rst_n <= 1'b0;
                                r_busy        <= 1'b1;
                                r_state       <= S_RST_CHAIN;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    S_RST_CHAIN: begin
                        if (r_phase_cnt == C_RST_LAST) begin
                            r_phase_cnt   <= '0;
                            r_chain_rst_n <= 1'b1;
                            r_state       <= S_SETTLE;
                        end else begin
                            r_phase_cnt <= r_phase_cnt + 16'd1;
                        end
                    end
                    S_SETTLE: begin
                        if (SETTLE_SAMPLES == 0) begin
                            r_state <= S_CAPTURE;
                        end else if (dsp_valid) begin
                            if (r_phase_cnt == C_SETTLE_LAST)
                                r_state <= S_CAPTURE;
                            else
                                r_phase_cnt <= r_phase_cnt + 16'd1;
                        end
                    end
                    S_CAPTURE: begin
                        if (w_drain && r_out_last) begin
                            r_state     <= S_IDLE;
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_done      <= 1'b1;
                        end else if (w_want && w_room) begin
                            r_out_data  <= dsp_data;
                            r_out_valid <= 1'b1;
                            r_out_last  <= (w_acc_next == r_len);
                            r_acc       <= w_acc_next;
                        end else begin
                            // Full and not draining: the sample is lost.
                            if (w_want)
                                r_overflow <= 1'b1;
                            if (w_drain) begin
                                r_out_valid <= 1'b0;
                                r_out_last  <= 1'b0;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign phi_inc     = r_phi_inc;
    assign chain_rst_n = r_chain_rst_n;
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign out_last    = r_out_last;
    assign busy        = r_busy;
    assign done        = r_done;
    assign cfg_rej     = r_cfg_rej;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ddc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddc_capture_ctrl
// Purpose  : Directed + randomized bench for ddc_capture_ctrl with a
//            cycle-level behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddc_capture_ctrl;

    localparam logic [31:0] FREQ_DEF = 32'h64000000;
    localparam int          RST_CYC  = 16;
    localparam int          SETTLE_N = 64;
    localparam int          P_IDLE = 0, P_RST = 1, P_SETTLE = 2, P_CAP = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cfg_freq = '0;
    logic        cfg_freq_we = 1'b0;
    logic [15:0] cfg_len = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] dsp_data = '0;
    logic        dsp_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] phi_inc;
    logic        chain_rst_n;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        cfg_rej;
    logic        overflow;

    ddc_capture_ctrl dut (
        .clk(clk), .reset_n(reset_n), .cfg_freq(cfg_freq), .cfg_freq_we(cfg_freq_we),
        .cfg_len(cfg_len), .start(start), .abort(abort), .dsp_data(dsp_data),
        .dsp_valid(dsp_valid), .phi_inc(phi_inc), .chain_rst_n(chain_rst_n),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .cfg_rej(cfg_rej),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int dv_period = 8;
    bit rdy_rand = 1'b0;
    int n_hs = 0;
    int n_done = 0;

    // Reference model state: what the controller should present after each edge.
    int          m_phase = P_IDLE;
    int          m_rst_left = 0, m_settle_left = 0, m_len = 0, m_acc = 0;
    logic [31:0] m_phi = FREQ_DEF, m_data = '0;
    logic        m_crn = 1'b0, m_vld = 1'b0, m_last = 1'b0;
    logic        m_done = 1'b0, m_rej = 1'b0, m_ov = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic drain;
        drain = m_vld && out_ready;
        if (!reset_n) begin
            m_phase = P_IDLE; m_phi = FREQ_DEF; m_crn = 1'b0; m_vld = 1'b0;
            m_last = 1'b0; m_done = 1'b0; m_rej = 1'b0; m_ov = 1'b0; m_data = '0; m_acc = 0;
        end else begin
            m_done = 1'b0;
            m_rej  = 1'b0;
            if (cfg_freq_we) begin
                if (m_phase == P_IDLE) m_phi = cfg_freq;
                else m_rej = 1'b1;
            end
            if (abort && m_phase != P_IDLE) begin
                m_phase = P_IDLE; m_vld = 1'b0; m_last = 1'b0; m_crn = 1'b1;
            end else if (m_phase == P_IDLE) begin
                m_crn = 1'b1;
                if (start && cfg_len != 0) begin
                    m_len = int'(cfg_len); m_acc = 0; m_ov = 1'b0; m_crn = 1'b0;
                    m_rst_left = RST_CYC; m_settle_left = SETTLE_N; m_phase = P_RST;
                end else if (start) begin
                    m_done = 1'b1;
                end
            end else if (m_phase == P_RST) begin
                m_rst_left--;
                if (m_rst_left == 0) begin
                    m_crn = 1'b1; m_phase = P_SETTLE;
                end
            end else if (m_phase == P_SETTLE) begin
                if (m_settle_left == 0) m_phase = P_CAP;
                else if (dsp_valid) begin
                    m_settle_left--;
                    if (m_settle_left == 0) m_phase = P_CAP;
                end
            end else begin
                if (drain && m_last) begin
                    m_phase = P_IDLE; m_vld = 1'b0; m_last = 1'b0; m_done = 1'b1;
                end else begin
                    if (drain) begin
                        m_vld = 1'b0; m_last = 1'b0;
                    end
                    if (dsp_valid && m_acc < m_len) begin
                        if (!m_vld) begin
                            m_data = dsp_data; m_vld = 1'b1; m_acc++;
                            m_last = (m_acc == m_len);
                        end else begin
                            m_ov = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic step();
        dsp_valid = (dv_period != 0) && ((cyc % dv_period) == 0);
        dsp_data  = $urandom;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) n_hs++;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        if (done) n_done++;
        chk("phi_inc", phi_inc, m_phi);
        chk("chain_rst_n", chain_rst_n, m_crn);
        chk("busy", busy, m_phase != P_IDLE);
        chk("done", done, m_done);
        chk("cfg_rej", cfg_rej, m_rej);
        chk("overflow", overflow, m_ov);
        chk("out_valid", out_valid, m_vld);
        chk("out_last", out_last, m_last);
        if (m_vld) chk("out_data", out_data, m_data);
        start = 1'b0; cfg_freq_we = 1'b0; abort = 1'b0;
    endtask

    task automatic begin_capture(input int len);
        cfg_len = 16'(len); start = 1'b1; n_hs = 0; n_done = 0;
        step();
    endtask

    task automatic run_to_idle(input int len);
        for (int k = 0; k < 4000 && m_phase != P_IDLE; k++) step();
        step();
        chk("words_delivered", n_hs, len);
        chk("done_pulses", n_done, 1);
    endtask

    task automatic wait_word(input int idx);
        for (int k = 0; k < 4000 && !(m_vld && m_acc == idx); k++) step();
    endtask

    initial begin
        // 1. reset then idle
        reset_n = 1'b0; repeat (3) step();
        reset_n = 1'b1; repeat (10) step();

        // 2. new frequency then a 4-word capture with ready held high
        cfg_freq = 32'h22222222; cfg_freq_we = 1'b1; step();
        begin_capture(4); run_to_idle(4);

        // 3. backpressure on the 2nd word causes overflow, capture still completes
        begin_capture(4);
        wait_word(2);
        out_ready = 1'b0; repeat (20) step();
        out_ready = 1'b1;
        run_to_idle(4);
        repeat (5) step();

        // 4. freq write during SETTLE rejected; start during CAPTURE ignored
        begin_capture(3);
        for (int k = 0; k < 100 && m_phase != P_SETTLE; k++) step();
        repeat (3) step();
        cfg_freq = $urandom; cfg_freq_we = 1'b1; step();
        for (int k = 0; k < 2000 && m_phase != P_CAP; k++) step();
        cfg_len = 16'd9; start = 1'b1; step();
        cfg_len = 16'd3;
        run_to_idle(3);

        // 5. abort on the 2nd word, then a normal 2-word capture
        begin_capture(4);
        wait_word(2);
        abort = 1'b1; step();
        repeat (10) step();
        chk("abort_no_done", n_done, 0);
        begin_capture(2); run_to_idle(2);

        // 6. zero-length start
        n_done = 0; n_hs = 0;
        cfg_len = 16'd0; start = 1'b1; step();
        repeat (5) step();
        chk("len0_done", n_done, 1);
        chk("len0_words", n_hs, 0);

        // 7. randomized captures; first one writes frequency alongside start
        for (int r = 0; r < 4; r++) begin
            int len;
            len = $urandom_range(1, 6);
            dv_period = $urandom_range(2, 5);
            rdy_rand = 1'b1;
            if (r == 0) begin
                cfg_freq = $urandom; cfg_freq_we = 1'b1;
            end
            begin_capture(len); run_to_idle(len);
            repeat (3) step();
        end

        // 8. reset during a capture restores defaults
        rdy_rand = 1'b0; out_ready = 1'b1; dv_period = 3;
        begin_capture(5);
        for (int k = 0; k < 2000 && m_phase != P_CAP; k++) step();
        repeat (4) step();
        reset_n = 1'b0; step();
        reset_n = 1'b1; repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
